// File: rtl/vx_issue_sched.sv
// Issue scheduler: round-robin pick among warps whose buffer head is valid and hazard-free,
// staged in a one-entry output register. Define ISSUE_SCHED_PERF_EN to add stall counters.
module vx_issue_sched #(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = 64,
    localparam int WW       = $clog2(NUM_WARPS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WARPS-1:0]       req_valid_i,
    input  logic [NUM_WARPS*DATAW-1:0] req_data_i,
    input  logic [NUM_WARPS-1:0]       sb_ready_i,
    output logic [NUM_WARPS-1:0]       req_ready_o,
    output logic                       out_valid_o,
    output logic [WW-1:0]              out_wid_o,
    output logic [DATAW-1:0]           out_data_o,
    input  logic                       out_ready_i
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_sb_stalls_o,
    output logic [31:0]                perf_ex_stalls_o
`endif
);

    logic [NUM_WARPS-1:0] eligible_s;
    logic                 can_load_s;
    logic                 found_s;
    logic                 fire_s;
    logic [WW-1:0]        idx_s;
    logic [WW-1:0]        grant_wid_s;

    logic                 out_valid_q, out_valid_d;
    logic [WW-1:0]        out_wid_q,   out_wid_d;
    logic [DATAW-1:0]     out_data_q,  out_data_d;
    logic [WW-1:0]        rr_ptr_q,    rr_ptr_d;

    assign eligible_s = req_valid_i & sb_ready_i;
    assign can_load_s = ~out_valid_q | out_ready_i;

    // First eligible warp at or above rr_ptr; WW-bit addition wraps modulo NUM_WARPS.
    always_comb begin
        found_s     = 1'b0;
        grant_wid_s = '0;
        idx_s       = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx_s = rr_ptr_q + WW'(i);
            if (!found_s && eligible_s[idx_s]) begin
                found_s     = 1'b1;
                grant_wid_s = idx_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    assign fire_s      = found_s & can_load_s & ~reset;
    assign req_ready_o = fire_s ? (NUM_WARPS'(1) << grant_wid_s) : '0;

    // Output stage next state: load on grant, drain on accept, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_wid_d   = out_wid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (fire_s) begin
            out_valid_d = 1'b1;
            out_wid_d   = grant_wid_s;
            out_data_d  = req_data_i[int'(grant_wid_s) * DATAW +: DATAW];
            rr_ptr_d    = grant_wid_s + WW'(1);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_wid_q   <= out_wid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_wid_o   = out_wid_q;
    assign out_data_o  = out_data_q;

`ifdef ISSUE_SCHED_PERF_EN
    logic        sb_stall_s;
    logic        ex_stall_s;
    logic [31:0] perf_sb_stalls_q;
    logic [31:0] perf_ex_stalls_q;

    // Scoreboard stall: work is present and the output could take it, but every head has a hazard.
    assign sb_stall_s = (|req_valid_i) & ~(|eligible_s) & can_load_s;
    assign ex_stall_s = out_valid_q & ~out_ready_i;

    // Saturating stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_sb_stalls_q <= 32'd0;
            perf_ex_stalls_q <= 32'd0;
        end else begin
            if (sb_stall_s && (perf_sb_stalls_q != 32'hFFFF_FFFF)) begin
                perf_sb_stalls_q <= perf_sb_stalls_q + 32'd1;
            end else begin
                perf_sb_stalls_q <= perf_sb_stalls_q;
            end
            if (ex_stall_s && (perf_ex_stalls_q != 32'hFFFF_FFFF)) begin
                perf_ex_stalls_q <= perf_ex_stalls_q + 32'd1;
            end else begin
                perf_ex_stalls_q <= perf_ex_stalls_q;
            end
        end
    end

    assign perf_sb_stalls_o = perf_sb_stalls_q;
    assign perf_ex_stalls_o = perf_ex_stalls_q;
`endif

endmodule

// File: tb/tb_vx_issue_sched.sv
// Scoreboard bench for vx_issue_sched: directed scenarios push expected issues,
// a negedge monitor pops and compares on every output handshake.
module tb_vx_issue_sched;

    localparam int NW = 4;
    localparam int DW = 64;

    typedef struct {
        logic [1:0]    wid;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NW-1:0]    req_valid;
    logic [NW*DW-1:0] req_data;
    logic [NW-1:0]    sb_ready;
    logic [NW-1:0]    req_ready;
    logic             out_valid;
    logic [1:0]       out_wid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0]      perf_sb_stalls;
    logic [31:0]      perf_ex_stalls;
`endif

    logic [DW-1:0] data_a [NW];
    exp_t          sb_q [$];
    int            checks = 0;
    int            errors = 0;

    vx_issue_sched #(.NUM_WARPS(NW), .DATAW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .sb_ready_i  (sb_ready),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_wid_o   (out_wid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
`ifdef ISSUE_SCHED_PERF_EN
        ,
        .perf_sb_stalls_o (perf_sb_stalls),
        .perf_ex_stalls_o (perf_ex_stalls)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int w = 0; w < NW; w++) req_data[w*DW +: DW] = data_a[w];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int wid, input logic [DW-1:0] data);
        exp_t e;
        e.wid  = 2'(wid);
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted output must match the oldest expected issue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=wid %0d required=no issue", out_wid);
            end else begin
                e = sb_q.pop_front();
                check("issue_wid", 64'(out_wid), 64'(e.wid));
                check("issue_data", out_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        sb_ready  = 4'b1111;
        out_ready = 1'b1;
        for (int w = 0; w < NW; w++) data_a[w] = 64'hC0DE_0000_0000_0000 + 64'(w * 32'h1111);

        // Reset state, with all warps requesting.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wid", 64'(out_wid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset = 1'b0;

        // Round robin over all warps.
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_req_ready", 64'(req_ready), 64'd1 << (i % 4));
            if (i > 0) check("rr_out_valid", 64'(out_valid), 64'd1);
            push(i % 4, data_a[i % 4]);
            step();
        end
        req_valid = 4'b0000;
        step();

        // Hazard skip: warps 0 and 2 blocked by the scoreboard.
        req_valid = 4'b1111;
        sb_ready  = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hz_req_ready", 64'(req_ready), (i == 1) ? 64'h8 : 64'h2);
            push((i == 1) ? 3 : 1, data_a[(i == 1) ? 3 : 1]);
            step();
        end
        req_valid = 4'b0000;
        sb_ready  = 4'b1111;
        step();
`ifdef ISSUE_SCHED_PERF_EN
        check("hz_perf_sb", 64'(perf_sb_stalls), 64'd0);
`endif

        // Back-pressure: rr_ptr is 2, issue warp 2 then stall three cycles.
        data_a[2] = 64'h0000_0000_0000_DEAD;
        req_valid = 4'b0100;
        #1;
        check("bp_req_ready_w2", 64'(req_ready), 64'h4);
        push(2, 64'h0000_0000_0000_DEAD);
        step();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        data_a[0] = 64'h5555_5555_5555_5555;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_wid", 64'(out_wid), 64'd2);
            check("bp_out_data", out_data, 64'h0000_0000_0000_DEAD);
            step();
        end
        out_ready = 1'b1;
        #1;
`ifdef ISSUE_SCHED_PERF_EN
        check("bp_perf_ex", 64'(perf_ex_stalls), 64'd3);
`endif
        check("bp_resume_grant", 64'(req_ready), 64'h8);
        push(3, data_a[3]);
        step();
        req_valid = 4'b0000;
        step();
        step();

        // All heads blocked with an empty output register.
        check("blk_start_valid", 64'(out_valid), 64'd0);
        req_valid = 4'b0110;
        sb_ready  = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("blk_req_ready", 64'(req_ready), 64'd0);
            check("blk_out_valid", 64'(out_valid), 64'd0);
            step();
        end
`ifdef ISSUE_SCHED_PERF_EN
        check("blk_perf_sb", 64'(perf_sb_stalls), 64'd5);
`endif

        // Reset mid-stall: load warp 1 (rr_ptr becomes 2), hold, then reset.
        sb_ready  = 4'b1111;
        req_valid = 4'b0010;
        out_ready = 1'b0;
        #1;
        check("rs_req_ready_w1", 64'(req_ready), 64'h2);
        step();
        req_valid = 4'b1111;
        reset     = 1'b1;
        #1;
        check("rs_forced_ready", 64'(req_ready), 64'd0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rs_out_valid", 64'(out_valid), 64'd0);
        check("rs_out_wid", 64'(out_wid), 64'd0);
        check("rs_out_data", out_data, 64'd0);
        check("rs_first_grant", 64'(req_ready), 64'h1);
`ifdef ISSUE_SCHED_PERF_EN
        check("rs_perf_ex", 64'(perf_ex_stalls), 64'd0);
`endif
        push(0, data_a[0]);
        step();
        req_valid = 4'b0000;
        step();
        step();

`ifdef ISSUE_SCHED_PERF_EN
        // Counter saturation from a preloaded value.
        req_valid = 4'b0010;
        #1;
        check("sat_req_ready", 64'(req_ready), 64'h2);
        push(1, data_a[1]);
        step();
        req_valid = 4'b0000;
        out_ready = 1'b0;
        force dut.perf_ex_stalls_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_ex_stalls_q;
        repeat (3) step();
        check("sat_perf_ex", 64'(perf_ex_stalls), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        step();
        step();
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
